// File: rtl/game_sequencer_if.sv
`default_nettype none
//============================================================================
// Module      : game_sequencer_if
// Description : Signal bundle between the game sequencer and its peers.
//               Carries hiscore when HISCORE_EN is defined.
// Revision    : 1.0 - initial release
//============================================================================
interface game_sequencer_if;
    logic        start_req;
    logic        vs;
    logic        px_dinosaur;
    logic        px_cactus;
    logic        game_status;
    logic        game_over;
    logic [3:0]  speed;
    logic [15:0] score;
    logic        frame_tick;
`ifdef HISCORE_EN
    logic [15:0] hiscore;

    modport master (
        output start_req, vs, px_dinosaur, px_cactus,
        input  game_status, game_over, speed, score, frame_tick, hiscore
    );
    modport slave (
        input  start_req, vs, px_dinosaur, px_cactus,
        output game_status, game_over, speed, score, frame_tick, hiscore
    );
`else
    modport master (
        output start_req, vs, px_dinosaur, px_cactus,
        input  game_status, game_over, speed, score, frame_tick
    );
    modport slave (
        input  start_req, vs, px_dinosaur, px_cactus,
        output game_status, game_over, speed, score, frame_tick
    );
`endif
endinterface
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
//============================================================================
// Module      : game_sequencer
// Description : IDLE/RUNNING/OVER game-flow controller with BCD score and
//               speed schedule, stepping at vs falling edges.
//               Optional macro HISCORE_EN adds a high-score register.
// Revision    : 1.0 - initial release
//============================================================================
module game_sequencer #(
    parameter int SPEED_INIT = 1,
    parameter int SPEED_MAX  = 15,
    parameter int SPEED_STEP = 600,
    parameter int OVER_HOLD  = 30
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    game_sequencer_if.slave bus
);

    localparam int c_FCNT_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam int c_HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
    localparam logic [3:0]          c_SPEED_INIT = 4'(SPEED_INIT);
    localparam logic [3:0]          c_SPEED_MAX  = 4'(SPEED_MAX);
    localparam logic [c_FCNT_W-1:0] c_STEP_LAST  = c_FCNT_W'(SPEED_STEP - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT  = c_HOLD_W'(OVER_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_vs_d;
    logic                  r_frame_tick;
    logic                  r_start_pend;
    logic                  r_hit;
    logic [c_HOLD_W-1:0]   r_hold_cnt;
    logic [c_FCNT_W-1:0]   r_frame_cnt;
    logic [3:0]            r_speed;
    logic [15:0]           r_score;
    logic                  r_game_status;
    logic                  r_game_over;

    state_t                w_state_nxt;
    logic                  w_enter_run;
    logic                  w_start_pend_nxt;
    logic                  w_hit_nxt;
    logic [c_HOLD_W-1:0]   w_hold_nxt;
    logic [c_FCNT_W-1:0]   w_frame_cnt_nxt;
    logic [3:0]            w_speed_nxt;
    logic [15:0]           w_score_nxt;
    logic [3:0]            w_dig_nine;
    logic [3:0]            w_carry;
    logic [15:0]           w_score_inc;

    // BCD increment: a digit rolls over only when every lower digit is 9
    always_comb begin
        w_carry[0] = 1'b1;
        for (int i = 1; i < 4; i++) begin
            w_carry[i] = w_carry[i-1] & w_dig_nine[i-1];
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        assign w_dig_nine[gi] = (r_score[4*gi +: 4] == 4'd9);
        assign w_score_inc[4*gi +: 4] = !w_carry[gi]   ? r_score[4*gi +: 4] :
                                        w_dig_nine[gi] ? 4'd0 :
                                                         r_score[4*gi +: 4] + 4'd1;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_enter_run     = 1'b0;
        w_hold_nxt      = r_hold_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_speed_nxt     = r_speed;
        w_score_nxt     = r_score;

        if (r_frame_tick) begin
            unique case (r_state)
                ST_IDLE: w_enter_run = r_start_pend;
                ST_RUN: begin
                    if (r_hit) begin
                        w_state_nxt = ST_OVER;
                        w_hold_nxt  = c_HOLD_INIT;
                    end else begin
                        w_score_nxt = (r_score == 16'h9999) ? r_score : w_score_inc;
                        if (r_frame_cnt == c_STEP_LAST) begin
                            w_frame_cnt_nxt = '0;
                            w_speed_nxt     = (r_speed >= c_SPEED_MAX) ? c_SPEED_MAX
                                                                       : r_speed + 4'd1;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    w_enter_run = r_start_pend;
                    if (!r_start_pend && (r_hold_cnt != '0)) begin
                        w_hold_nxt = r_hold_cnt - 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_enter_run) begin
            w_state_nxt     = ST_RUN;
            w_score_nxt     = '0;
            w_speed_nxt     = c_SPEED_INIT;
            w_frame_cnt_nxt = '0;
        end

        // Start requests are only accepted while a new game may begin
        w_start_pend_nxt = r_start_pend;
        if (w_enter_run) begin
            w_start_pend_nxt = 1'b0;
        end else if (bus.start_req &&
                     ((r_state == ST_IDLE) ||
                      ((r_state == ST_OVER) && (r_hold_cnt == '0)))) begin
            w_start_pend_nxt = 1'b1;
        end

        w_hit_nxt = r_hit;
        if (w_enter_run) begin
            w_hit_nxt = 1'b0;
        end else if ((r_state == ST_RUN) && bus.px_dinosaur && bus.px_cactus) begin
            w_hit_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_vs_d        <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_start_pend  <= 1'b0;
            r_hit         <= 1'b0;
            r_hold_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_speed       <= c_SPEED_INIT;
            r_score       <= '0;
            r_game_status <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_vs_d        <= bus.vs;
            r_frame_tick  <= r_vs_d & ~bus.vs;
            r_start_pend  <= w_start_pend_nxt;
            r_hit         <= w_hit_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_speed       <= w_speed_nxt;
            r_score       <= w_score_nxt;
            r_game_status <= (w_state_nxt == ST_RUN);
            r_game_over   <= (w_state_nxt == ST_OVER);
        end
    end

`ifdef HISCORE_EN
    logic [15:0] r_hiscore;

    // BCD words order the same way as their decimal values
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hiscore <= '0;
        end else if (r_frame_tick && (r_state == ST_RUN) && r_hit &&
                     (r_score > r_hiscore)) begin
            r_hiscore <= r_score;
        end
    end

    assign bus.hiscore = r_hiscore;
`endif

    assign bus.game_status = r_game_status;
    assign bus.game_over   = r_game_over;
    assign bus.speed       = r_speed;
    assign bus.score       = r_score;
    assign bus.frame_tick  = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_game_sequencer
// Description : Randomized self-checking bench for game_sequencer against a
//               frame-level behavioural model (integer score, decimal digits).
// Revision    : 1.0 - initial release
//============================================================================
module tb_game_sequencer;

    localparam int SPEED_INIT = 1;
    localparam int SPEED_MAX  = 15;
    localparam int SPEED_STEP = 4;
    localparam int OVER_HOLD  = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_OVER = 2;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_each = 1'b1;

    game_sequencer_if bus();

    game_sequencer #(
        .SPEED_INIT (SPEED_INIT),
        .SPEED_MAX  (SPEED_MAX),
        .SPEED_STEP (SPEED_STEP),
        .OVER_HOLD  (OVER_HOLD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state
    int m_state, m_hold, m_fcnt, m_speed, m_score, m_hi;
    bit m_vs_d, m_tick, m_pend, m_hit;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model(input logic sr, input logic pd, input logic pc,
                         input logic v, input logic rst);
        int ns, nhold, nfcnt, nspeed, nscore, nhi;
        bit enter;
        if (rst) begin
            m_state = M_IDLE; m_hold = 0; m_fcnt = 0; m_speed = SPEED_INIT;
            m_score = 0; m_hi = 0; m_vs_d = 0; m_tick = 0; m_pend = 0; m_hit = 0;
            return;
        end
        ns = m_state; nhold = m_hold; nfcnt = m_fcnt; nspeed = m_speed;
        nscore = m_score; nhi = m_hi;
        enter = m_tick && m_pend && (m_state != M_RUN);
        if (m_tick) begin
            if (m_state == M_RUN) begin
                if (m_hit) begin
                    ns = M_OVER;
                    nhold = OVER_HOLD;
                    if (m_score > m_hi) nhi = m_score;
                end else begin
                    nscore = (m_score < 9999) ? m_score + 1 : 9999;
                    nfcnt = (m_fcnt + 1) % SPEED_STEP;
                    if (nfcnt == 0) nspeed = (m_speed < SPEED_MAX) ? m_speed + 1 : SPEED_MAX;
                end
            end else if (enter) begin
                ns = M_RUN; nscore = 0; nspeed = SPEED_INIT; nfcnt = 0;
            end else if (m_state == M_OVER && m_hold > 0) begin
                nhold = m_hold - 1;
            end
        end
        m_pend = enter ? 1'b0 :
                 (m_pend || (sr && (m_state == M_IDLE || (m_state == M_OVER && m_hold == 0))));
        m_hit  = enter ? 1'b0 : (m_hit || (m_state == M_RUN && pd && pc));
        m_state = ns; m_hold = nhold; m_fcnt = nfcnt; m_speed = nspeed;
        m_score = nscore; m_hi = nhi;
        m_tick = m_vs_d & ~v;
        m_vs_d = v;
    endtask

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".game_status"}, 16'(bus.game_status), 16'(m_state == M_RUN));
        cmp({tag, ".game_over"},   16'(bus.game_over),   16'(m_state == M_OVER));
        cmp({tag, ".speed"},       16'(bus.speed),       16'(m_speed));
        cmp({tag, ".score"},       bus.score,            to_bcd(m_score));
        cmp({tag, ".frame_tick"},  16'(bus.frame_tick),  16'(m_tick));
`ifdef HISCORE_EN
        cmp({tag, ".hiscore"},     bus.hiscore,          to_bcd(m_hi));
`endif
    endtask

    task automatic cyc(input logic sr, input logic pd, input logic pc,
                       input logic v, input logic rst);
        @(negedge CLK);
        RESET = rst;
        bus.start_req = sr; bus.px_dinosaur = pd; bus.px_cactus = pc; bus.vs = v;
        @(posedge CLK);
        model(sr, pd, pc, v, rst);
        #1;
        if (chk_each) check_all("cycle");
    endtask

    // One frame: vs low on the last cycle; optional start pulse / collision cycle
    task automatic frame(input int len, input int start_at, input int hit_at,
                         input bit rnd, input string tag);
        logic pd, pc;
        for (int i = 0; i < len; i++) begin
            pd = rnd ? logic'($urandom_range(1, 0)) : 1'b0;
            pc = rnd ? (~pd & logic'($urandom_range(1, 0))) : 1'b0;
            if (i == hit_at) begin pd = 1'b1; pc = 1'b1; end
            cyc(logic'(i == start_at), pd, pc, logic'(i != len - 1), 1'b0);
        end
        check_all(tag);
    endtask

    initial begin
        int len, sa, ha;
        bus.start_req = 0; bus.vs = 1; bus.px_dinosaur = 0; bus.px_cactus = 0;

        // Reset, then idle frames
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cmp("reset.speed", 16'(bus.speed), 16'd1);
        cmp("reset.score", bus.score, 16'h0000);
        for (int f = 0; f < 5; f++) frame(6, -1, -1, 1'b1, "idle");
        cmp("idle.status", 16'(bus.game_status), 16'd0);

        // One-cycle start pulse mid-frame, then the entering frame
        frame(8, 3, -1, 1'b0, "start_pulse");
        cmp("start.not_yet", 16'(bus.game_status), 16'd0);
        frame(8, -1, -1, 1'b1, "enter");
        cmp("enter.status", 16'(bus.game_status), 16'd1);
        cmp("enter.score", bus.score, 16'h0000);
        cmp("enter.speed", 16'(bus.speed), 16'd1);

        for (int f = 0; f < 12; f++) frame(6, -1, -1, 1'b1, "run12");
        cmp("run12.score", bus.score, 16'h0012);
        cmp("run12.speed", 16'(bus.speed), 16'd4);
        for (int f = 0; f < 68; f++) frame(5, -1, -1, 1'b1, "run80");
        cmp("run80.speed_sat", 16'(bus.speed), 16'd15);

        // Collision on the vs-low cycle, then hold window with ignored starts
        frame(6, -1, 5, 1'b0, "hit_last_line");
        frame(6, 3, -1, 1'b0, "over1");
        cmp("over1.game_over", 16'(bus.game_over), 16'd1);
        frame(6, 3, -1, 1'b0, "over2");
        frame(6, 3, -1, 1'b0, "over3");
        frame(6, 3, -1, 1'b0, "over4");
        cmp("over4.still_over", 16'(bus.game_over), 16'd1);
        frame(6, -1, -1, 1'b0, "over5");
        cmp("restart.status", 16'(bus.game_status), 16'd1);
        cmp("restart.score", bus.score, 16'h0000);

        // Score to 0x37 then single-cycle collision
        for (int f = 0; f < 36; f++) frame(5, -1, -1, 1'b1, "to37");
        frame(7, -1, 3, 1'b0, "hit37");
        cmp("hit37.score", bus.score, 16'h0037);
        for (int f = 0; f < 10; f++) frame(5, -1, -1, 1'b1, "frozen");
        cmp("frozen.over", 16'(bus.game_over), 16'd1);
        cmp("frozen.score", bus.score, 16'h0037);
        cmp("frozen.speed", 16'(bus.speed), 16'd10);
`ifdef HISCORE_EN
        cmp("hiscore.kept", bus.hiscore, 16'h0081);
`endif

        // Randomized play: random frame lengths, starts and collisions
        for (int f = 0; f < 60; f++) begin
            len = $urandom_range(10, 3);
            sa  = ($urandom_range(2, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            ha  = ($urandom_range(4, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            frame(len, sa, ha, 1'b1, "random");
        end

        // Long run to BCD saturation
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        chk_each = 1'b0;
        frame(4, 1, -1, 1'b0, "sat_start");
        frame(4, -1, -1, 1'b0, "sat_enter");
        for (int f = 0; f < 9998; f++) frame(4, -1, -1, 1'b0, "long");
        cmp("long.score", bus.score, 16'h9998);
        chk_each = 1'b1;
        for (int f = 0; f < 3; f++) frame(4, -1, -1, 1'b0, "sat");
        cmp("sat.score", bus.score, 16'h9999);
        frame(5, -1, 2, 1'b0, "sat_hit");
        frame(5, -1, -1, 1'b0, "sat_over");
`ifdef HISCORE_EN
        cmp("hiscore.9999", bus.hiscore, 16'h9999);
`endif

        // Restart and reset mid-game
        for (int f = 0; f < 4; f++) frame(5, 2, -1, 1'b0, "restart2");
        frame(6, -1, -1, 1'b1, "pre_reset");
        cmp("pre_reset.status", 16'(bus.game_status), 16'd1);
        cyc(0, 0, 0, 1, 1);
        cmp("midreset.status", 16'(bus.game_status), 16'd0);
        cmp("midreset.score", bus.score, 16'h0000);
        cmp("midreset.speed", 16'(bus.speed), 16'd1);
`ifdef HISCORE_EN
        cmp("midreset.hiscore", bus.hiscore, 16'h0000);
`endif
        for (int f = 0; f < 2; f++) frame(6, -1, -1, 1'b1, "post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
